// File: rtl/json.sv
`default_nettype none
// ---------------------------------------------------------------------------
// json : flat JSON object pair counter (cur_num / max_num); opt. JSON_STRICT_EN
// Revision: 1.0
// ---------------------------------------------------------------------------
module json (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char,
  output logic [7:0] cur_num,
  output logic [7:0] max_num
);

  typedef enum logic [1:0] {
    ST_OUT = 2'd0,
    ST_OBJ = 2'd1,
    ST_STR = 2'd2
  } state_e;

  localparam logic [7:0] C_LBRACE = 8'h7B;
  localparam logic [7:0] C_RBRACE = 8'h7D;
  localparam logic [7:0] C_QUOTE  = 8'h22;
  localparam logic [7:0] C_COLON  = 8'h3A;
  localparam logic [7:0] C_COMMA  = 8'h2C;
  localparam logic [7:0] C_SPACE  = 8'h20;
  localparam logic [7:0] C_TAB    = 8'h09;
  localparam logic [7:0] C_CR     = 8'h0D;
  localparam logic [7:0] C_LF     = 8'h0A;

  state_e     state_q, state_d;
  logic [7:0] cur_num_q, cur_num_d;
  logic [7:0] max_num_q, max_num_d;
  logic       invalid_q, invalid_d;

  always_comb begin
    state_d   = state_q;
    cur_num_d = cur_num_q;
    max_num_d = max_num_q;
    invalid_d = invalid_q;
    case (state_q)
      ST_OUT: begin
        if (char == C_LBRACE) begin
          cur_num_d = 8'd0;
          invalid_d = 1'b0;
          state_d   = ST_OBJ;
        end
      end
      ST_OBJ: begin
        case (char)
          C_QUOTE: state_d = ST_STR;
          C_COLON: begin
            if (cur_num_q != 8'hFF) cur_num_d = cur_num_q + 8'd1;
          end
          C_RBRACE: begin
            // cur_num is left alone so the final count stays visible
            if (!invalid_q && (cur_num_q > max_num_q)) max_num_d = cur_num_q;
            state_d = ST_OUT;
          end
          C_LBRACE: begin
            cur_num_d = 8'd0;
            invalid_d = 1'b0;
          end
          C_COMMA, C_SPACE, C_TAB, C_CR, C_LF: ;
          default: begin
`ifdef JSON_STRICT_EN
            invalid_d = 1'b1;
`else
            invalid_d = 1'b0;
`endif
          end
        endcase
      end
      ST_STR: begin
        if (char == C_QUOTE) state_d = ST_OBJ;
      end
      default: state_d = ST_OUT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_OUT;
      cur_num_q <= 8'd0;
      max_num_q <= 8'd0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_num_q <= cur_num_d;
      max_num_q <= max_num_d;
      invalid_q <= invalid_d;
    end
  end

  assign cur_num = cur_num_q;
  assign max_num = max_num_q;

endmodule
`default_nettype wire

// File: tb/tb_json.sv
`default_nettype none
// tb_json : directed self-checking bench for the json pair counter.
module tb_json;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ch = 8'h00;
  logic [7:0] cur_num;
  logic [7:0] max_num;
  int errors = 0;
  int checks = 0;

  json dut (
    .clk     (clk),
    .reset   (reset),
    .char    (ch),
    .cur_num (cur_num),
    .max_num (max_num)
  );

  always #5 clk = ~clk;

  task automatic send_char(input logic [7:0] c);
    ch = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    ch = 8'h7B;
    @(posedge clk);
    #1;
    reset = 1'b0;
    ch = 8'h00;
  endtask

  task automatic test_reset();
    pulse_reset();
    pulse_reset();
    checks++; if (cur_num !== 8'd0) begin errors++; $display("FAIL reset_cur got=%0d exp=0", cur_num); end
    checks++; if (max_num !== 8'd0) begin errors++; $display("FAIL reset_max got=%0d exp=0", max_num); end
  endtask

  task automatic test_basic();
    send_str("{\"key\"");
    send_char(8'h3A);
    checks++; if (cur_num !== 8'd1) begin errors++; $display("FAIL colon_latency got=%0d exp=1", cur_num); end
    checks++; if (max_num !== 8'd0) begin errors++; $display("FAIL open_obj_max got=%0d exp=0", max_num); end
    send_str("\"value\"}");
    checks++; if (cur_num !== 8'd1) begin errors++; $display("FAIL basic_cur got=%0d exp=1", cur_num); end
    checks++; if (max_num !== 8'd1) begin errors++; $display("FAIL basic_max got=%0d exp=1", max_num); end
  endtask

  task automatic test_multi();
    send_str(" {\"k\":\"v\",\"k\":\"v\"}");
    checks++; if (cur_num !== 8'd2) begin errors++; $display("FAIL two_cur got=%0d exp=2", cur_num); end
    checks++; if (max_num !== 8'd2) begin errors++; $display("FAIL two_max got=%0d exp=2", max_num); end
    send_str(" {\"a\":\"b\",\"c\":\"d\",\"e\":\"f\"}");
    checks++; if (cur_num !== 8'd3) begin errors++; $display("FAIL three_cur got=%0d exp=3", cur_num); end
    checks++; if (max_num !== 8'd3) begin errors++; $display("FAIL three_max got=%0d exp=3", max_num); end
  endtask

  task automatic test_empty();
    send_str(" {\"\":\"value\"}");
    checks++; if (cur_num !== 8'd1) begin errors++; $display("FAIL emptykey_cur got=%0d exp=1", cur_num); end
    checks++; if (max_num !== 8'd3) begin errors++; $display("FAIL emptykey_max got=%0d exp=3", max_num); end
    send_str("{}");
    checks++; if (cur_num !== 8'd0) begin errors++; $display("FAIL emptyobj_cur got=%0d exp=0", cur_num); end
    checks++; if (max_num !== 8'd3) begin errors++; $display("FAIL emptyobj_max got=%0d exp=3", max_num); end
    send_char(8'h00);
    send_char(8'h3A);
    send_char(8'h7D);
    checks++; if (cur_num !== 8'd0) begin errors++; $display("FAIL out_ignore_cur got=%0d exp=0", cur_num); end
  endtask

  task automatic test_strings();
    send_str("{\"a:}b\":\"c{\"}");
    checks++; if (cur_num !== 8'd1) begin errors++; $display("FAIL str_cur got=%0d exp=1", cur_num); end
    checks++; if (max_num !== 8'd3) begin errors++; $display("FAIL str_max got=%0d exp=3", max_num); end
  endtask

  task automatic test_restart();
    send_str("{\"a\":\"b\"{\"c\":\"d\"}");
    checks++; if (cur_num !== 8'd1) begin errors++; $display("FAIL restart_cur got=%0d exp=1", cur_num); end
    checks++; if (max_num !== 8'd3) begin errors++; $display("FAIL restart_max got=%0d exp=3", max_num); end
  endtask

  task automatic test_reset_mid_and_saturate();
    send_str("{\"a\":\"b\",\"c\":\"d\"");
    checks++; if (cur_num !== 8'd2) begin errors++; $display("FAIL mid_cur got=%0d exp=2", cur_num); end
    pulse_reset();
    checks++; if (cur_num !== 8'd0) begin errors++; $display("FAIL midrst_cur got=%0d exp=0", cur_num); end
    checks++; if (max_num !== 8'd0) begin errors++; $display("FAIL midrst_max got=%0d exp=0", max_num); end
    send_str("{}");
    checks++; if (cur_num !== 8'd0) begin errors++; $display("FAIL postrst_cur got=%0d exp=0", cur_num); end
    checks++; if (max_num !== 8'd0) begin errors++; $display("FAIL postrst_max got=%0d exp=0", max_num); end
    send_char(8'h7B);
    for (int i = 0; i < 300; i++) send_str("\"a\":\"b\",");
    checks++; if (cur_num !== 8'd255) begin errors++; $display("FAIL sat_cur got=%0d exp=255", cur_num); end
    checks++; if (max_num !== 8'd0) begin errors++; $display("FAIL sat_open_max got=%0d exp=0", max_num); end
    send_char(8'h7D);
    checks++; if (cur_num !== 8'd255) begin errors++; $display("FAIL sat_close_cur got=%0d exp=255", cur_num); end
    checks++; if (max_num !== 8'd255) begin errors++; $display("FAIL sat_close_max got=%0d exp=255", max_num); end
    send_str(" {\"a\":\"b\"}");
    checks++; if (max_num !== 8'd255) begin errors++; $display("FAIL nodecrease_max got=%0d exp=255", max_num); end
  endtask

  task automatic test_strict();
    logic [7:0] exp_max;
`ifdef JSON_STRICT_EN
    exp_max = 8'd1;
`else
    exp_max = 8'd2;
`endif
    pulse_reset();
    send_str("{\"a\":\"b\"}");
    checks++; if (max_num !== 8'd1) begin errors++; $display("FAIL strict_pre_max got=%0d exp=1", max_num); end
    send_str("{\"a\":\"b\",x,\"c\":\"d\"}");
    checks++; if (cur_num !== 8'd2) begin errors++; $display("FAIL strict_cur got=%0d exp=2", cur_num); end
    checks++; if (max_num !== exp_max) begin errors++; $display("FAIL strict_max got=%0d exp=%0d", max_num, exp_max); end
    send_str("{x{\"a\":\"b\",\r\n\t\"c\":\"d\", \"e\":\"f\"}");
    checks++; if (cur_num !== 8'd3) begin errors++; $display("FAIL strict_clear_cur got=%0d exp=3", cur_num); end
    checks++; if (max_num !== 8'd3) begin errors++; $display("FAIL strict_clear_max got=%0d exp=3", max_num); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi();
    test_empty();
    test_strings();
    test_restart();
    test_reset_mid_and_saturate();
    test_strict();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
